// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

   localparam int unsigned BCD_W         = 4;
   localparam int unsigned BCD_MAX       = 9;
   localparam int unsigned SEC_TENS_WRAP = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD display digit: loadable by shifting, decremented through a borrow chain.
module bcd_down_digit
   import timer_pkg::*;
#(
   parameter int unsigned WRAP = BCD_MAX
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             shift,
   input  logic [BCD_W-1:0] shift_in,
   input  logic             borrow_in,
   output logic [BCD_W-1:0] digit,
   output logic             borrow_out_c
);

   // A digit at 0 that is asked to decrement wraps and passes the borrow on.
   assign borrow_out_c = borrow_in && (digit == '0);

   always_ff @(posedge clk) begin
      if (clear) begin
         digit <= '0;
      end else if (shift) begin
         digit <= shift_in;
      end else if (borrow_in) begin
         digit <= (digit == '0) ? BCD_W'(WRAP) : digit - BCD_W'(1);
      end
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Keypad-loaded BCD countdown timer (mm..:ss) with run/pause/cancel control.
module bcd_countdown_timer
   import timer_pkg::*;
#(
   parameter int unsigned MIN_DIGITS = 1,
   parameter bit          TICK_EN    = 1'b1
) (
   input  logic                      clk,
   input  logic                      clear,
   input  logic [3:0]                data,
   input  logic                      load,
   input  logic                      start,
   input  logic                      pause,
   input  logic                      tick,
   output logic [3:0]                unidades,
   output logic [3:0]                dezenas,
   output logic [4*MIN_DIGITS-1:0]   minutos,
   output logic                      zero,
   output logic                      running,
   output logic                      done
);

   localparam int unsigned NDIG = MIN_DIGITS + 2;

   state_t           state_q, state_d;
   logic             done_d, shift, dec, cancel;
   logic             pause_eff, start_eff, load_eff, tick_eff, is_one;
   logic [BCD_W-1:0] dig       [NDIG];
   logic [BCD_W-1:0] shift_src [NDIG];
   logic [NDIG:0]    borrow;
   logic             underflow_unused;

   assign borrow[0]        = dec;
   assign shift_src[0]     = data;
   // Decrements only happen on a non-zero count, so the top borrow never fires.
   assign underflow_unused = borrow[NDIG];

   // Digit 0 = seconds units, 1 = seconds tens, 2.. = minutes (LSD first).
   for (genvar i = 0; i < NDIG; i++) begin : g_dig
      if (i > 0) begin : g_src
         assign shift_src[i] = dig[i-1];
      end
      bcd_down_digit #(
         .WRAP ((i == 1) ? SEC_TENS_WRAP : BCD_MAX)
      ) u_digit (
         .clk          (clk),
         .clear        (clear | cancel),
         .shift        (shift),
         .shift_in     (shift_src[i]),
         .borrow_in    (borrow[i]),
         .digit        (dig[i]),
         .borrow_out_c (borrow[i+1])
      );
   end

   assign unidades = dig[0];
   assign dezenas  = dig[1];
   for (genvar m = 0; m < MIN_DIGITS; m++) begin : g_min
      assign minutos[4*m +: 4] = dig[m+2];
   end

   // Count-state detection: all zero, and exactly 00:01.
   always_comb begin
      zero   = 1'b1;
      is_one = (dig[0] == BCD_W'(1));
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (dig[i] != '0) zero = 1'b0;
      end
      for (int unsigned i = 1; i < NDIG; i++) begin
         if (dig[i] != '0) is_one = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= IDLE;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         running <= (state_d == RUN);
         done    <= done_d;
      end
   end

   // Only controls that are meaningful in the current state take part in the priority.
   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      shift     = 1'b0;
      dec       = 1'b0;
      cancel    = 1'b0;
      pause_eff = pause && (state_q == RUN || state_q == PAUSED);
      start_eff = start && ((state_q == IDLE && !zero) || state_q == PAUSED);
      load_eff  = load && (data <= BCD_W'(BCD_MAX)) &&
                  (state_q == IDLE || state_q == DONE);
      tick_eff  = (TICK_EN ? tick : 1'b1) && (state_q == RUN);

      if (pause_eff) begin
         if (state_q == RUN) begin
            state_d = PAUSED;
         end else begin
            state_d = IDLE;
            cancel  = 1'b1;
         end
      end else if (start_eff) begin
         state_d = RUN;
      end else if (load_eff) begin
         shift   = 1'b1;
         state_d = IDLE;
      end else if (tick_eff) begin
         dec = 1'b1;
         if (is_one) begin
            state_d = DONE;
            done_d  = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (two minute digits, tick-driven).
module tb_bcd_countdown_timer;

   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

   logic        clk = 1'b0;
   logic        clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
   logic [3:0]  data = 4'd0;
   logic [3:0]  unidades, dezenas;
   logic [7:0]  minutos;
   logic        zero, running, done;
   logic [15:0] disp;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   // Reference model: minutes and seconds as plain decimal numbers.
   int m_mins = 0, m_secs = 0, m_state = S_IDLE;
   bit m_done = 1'b0;

   bcd_countdown_timer #(.MIN_DIGITS(2), .TICK_EN(1'b1)) dut (
      .clk(clk), .clear(clear), .data(data), .load(load), .start(start),
      .pause(pause), .tick(tick), .unidades(unidades), .dezenas(dezenas),
      .minutos(minutos), .zero(zero), .running(running), .done(done)
   );

   assign disp = {minutos, dezenas, unidades};

   always #5 clk = ~clk;

   task automatic model_step(input bit cl, ld, input logic [3:0] d, input bit st, ps, tk);
      int full;
      bit mz;
      mz     = (m_mins == 0 && m_secs == 0);
      m_done = 1'b0;
      if (cl) begin
         m_state = S_IDLE; m_mins = 0; m_secs = 0;
      end else if (ps && (m_state == S_RUN || m_state == S_PAUSED)) begin
         if (m_state == S_RUN) m_state = S_PAUSED;
         else begin m_state = S_IDLE; m_mins = 0; m_secs = 0; end
      end else if (st && ((m_state == S_IDLE && !mz) || m_state == S_PAUSED)) begin
         m_state = S_RUN;
      end else if (ld && d <= 4'd9 && (m_state == S_IDLE || m_state == S_DONE)) begin
         full    = ((m_mins * 100 + m_secs) * 10 + int'(d)) % 10000;
         m_mins  = full / 100;
         m_secs  = full % 100;
         m_state = S_IDLE;
      end else if (tk && m_state == S_RUN) begin
         if (m_secs > 0) m_secs = m_secs - 1;
         else begin m_mins = m_mins - 1; m_secs = 59; end
         if (m_mins == 0 && m_secs == 0) begin m_state = S_DONE; m_done = 1'b1; end
      end
   endtask

   // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
   task automatic drive(input bit cl, ld, input logic [3:0] d, input bit st, ps, tk);
      clear = cl; load = ld; data = d; start = st; pause = ps; tick = tk;
      @(posedge clk);
      model_step(cl, ld, d, st, ps, tk);
      #1;
      clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
      if (done === 1'b1) done_seen++;
   endtask

   task automatic do_clear();                 drive(1, 0, 4'd0, 0, 0, 0); done_seen = 0; endtask
   task automatic do_load(input logic [3:0] d); drive(0, 1, d, 0, 0, 0); endtask
   task automatic do_start(input bit tk);     drive(0, 0, 4'd0, 1, 0, tk); endtask
   task automatic do_pause(input bit tk);     drive(0, 0, 4'd0, 0, 1, tk); endtask
   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 4'd0, 0, 0, 1);
   endtask

   task automatic test_reset();
      do_clear();
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h expected 0000", disp); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", zero); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
   endtask

   task automatic test_countdown_130();
      int done_at = -1;
      do_clear();
      do_load(4'd1); do_load(4'd3); do_load(4'd0);
      checks++; if (disp !== 16'h0130) begin errors++; $display("FAIL load_0130: got %h expected 0130", disp); end
      do_start(0);
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running: got %b expected 1", running); end
      for (int i = 0; i < 90; i++) begin
         do_ticks(1);
         if (done === 1'b1) begin
            done_at = i;
            checks++; if (zero !== 1'b1) begin errors++; $display("FAIL done_with_zero: got zero=%b expected 1", zero); end
         end
      end
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL count_130_end: got %h expected 0000", disp); end
      checks++; if (done_at != 89) begin errors++; $display("FAIL done_cycle: got tick %0d expected 89", done_at); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL done_not_running: got %b expected 0", running); end
      do_start(1); do_pause(0); do_ticks(3);
      checks++; if (done_seen != 1) begin errors++; $display("FAIL done_once: got %0d pulses expected 1", done_seen); end
      checks++; if (running !== 1'b0 || disp !== 16'h0000) begin errors++; $display("FAIL done_hold: got run=%b disp=%h expected 0/0000", running, disp); end
      do_load(4'd2); do_start(0); do_ticks(1);
      checks++; if (disp !== 16'h0001) begin errors++; $display("FAIL reload_from_done: got %h expected 0001", disp); end
   endtask

   task automatic test_tens_wrap();
      do_clear();
      do_load(4'd9); do_load(4'd0); do_start(0); do_ticks(1);
      checks++; if (disp !== 16'h0089) begin errors++; $display("FAIL tens_90: got %h expected 0089", disp); end
      do_load(4'hA);
      checks++; if (disp !== 16'h0089) begin errors++; $display("FAIL load_in_run: got %h expected 0089", disp); end
   endtask

   task automatic test_pause_resume();
      do_clear();
      do_load(4'd12); do_load(4'd0); do_load(4'd0); do_load(4'd5);
      checks++; if (disp !== 16'h0005) begin errors++; $display("FAIL load_bad_digit: got %h expected 0005", disp); end
      do_start(1);
      checks++; if (disp !== 16'h0005) begin errors++; $display("FAIL start_tick_ignored: got %h expected 0005", disp); end
      do_ticks(3);
      do_pause(1);
      checks++; if (disp !== 16'h0002) begin errors++; $display("FAIL pause_beats_tick: got %h expected 0002", disp); end
      do_ticks(5);
      checks++; if (disp !== 16'h0002 || running !== 1'b0) begin errors++; $display("FAIL paused_hold: got %h run=%b expected 0002 run=0", disp, running); end
      do_start(0); do_ticks(2);
      checks++; if (disp !== 16'h0000 || done_seen != 1) begin errors++; $display("FAIL resume_done: got %h pulses=%0d expected 0000 pulses=1", disp, done_seen); end
   endtask

   task automatic test_full_borrow();
      do_clear();
      do_load(4'd1); do_load(4'd0); do_load(4'd0); do_load(4'd0);
      do_start(0); do_ticks(1);
      checks++; if (disp !== 16'h0959) begin errors++; $display("FAIL borrow_1000: got %h expected 0959", disp); end
      do_clear();
      for (int i = 0; i < 5; i++) do_load(4'd9);
      checks++; if (disp !== 16'h9999) begin errors++; $display("FAIL load_full: got %h expected 9999", disp); end
      do_start(0); do_ticks(100);
      checks++; if (disp !== 16'h9859) begin errors++; $display("FAIL full_scale: got %h expected 9859", disp); end
   endtask

   task automatic test_cancel();
      do_clear();
      do_load(4'd4); do_load(4'd5); do_start(0); do_pause(0); do_pause(0);
      checks++; if (disp !== 16'h0000 || zero !== 1'b1) begin errors++; $display("FAIL cancel_digits: got %h zero=%b expected 0000 zero=1", disp, zero); end
      do_start(0);
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_on_zero: got %b expected 0", running); end
   endtask

   task automatic test_clear_mid_run();
      do_clear();
      do_load(4'd0); do_load(4'd1); do_start(0);
      drive(1, 0, 4'd0, 0, 0, 1);
      checks++; if (disp !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL clear_mid_run: got %h run=%b done=%b expected 0000/0/0", disp, running, done); end
      do_ticks(3);
      checks++; if (done_seen != 0) begin errors++; $display("FAIL no_done_after_clear: got %0d pulses expected 0", done_seen); end
   endtask

   task automatic test_random();
      logic [15:0] exp_disp;
      bit ld, st, ps, cl, tk;
      int op;
      do_clear();
      for (int n = 0; n < 600; n++) begin
         op = int'($urandom_range(0, 9));
         ld = (op <= 2); st = (op == 3); ps = (op == 4);
         cl = ($urandom_range(0, 59) == 0);
         tk = ($urandom_range(0, 1) == 0);
         drive(cl, ld, 4'($urandom_range(0, 11)), st, ps, tk);
         exp_disp = {4'(m_mins / 10), 4'(m_mins % 10), 4'(m_secs / 10), 4'(m_secs % 10)};
         checks++; if (disp !== exp_disp) begin errors++; $display("FAIL rand_digits[%0d]: got %h expected %h", n, disp, exp_disp); end
         checks++; if (zero !== (m_mins == 0 && m_secs == 0)) begin errors++; $display("FAIL rand_zero[%0d]: got %b", n, zero); end
         checks++; if (running !== (m_state == S_RUN)) begin errors++; $display("FAIL rand_running[%0d]: got %b expected %b", n, running, m_state == S_RUN); end
         checks++; if (done !== m_done) begin errors++; $display("FAIL rand_done[%0d]: got %b expected %b", n, done, m_done); end
      end
   endtask

   initial begin
      test_reset();
      test_countdown_130();
      test_tens_wrap();
      test_pause_resume();
      test_full_borrow();
      test_cancel();
      test_clear_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
